setcc_pipe: RTL
===============

// Module: setcc_pipe
// PURPOSE
//  Parametrised, pipelined successor of the setcc condition-code unit.
//  - Executes ADD/SUB/CMP/ADDC/SUBB on WIDTH-bit operands.
//  - Holds an architectural CCR (c,z,n,v) plus a sticky-overflow bit (sv).
//  - Evaluates a 4-bit branch condition against the CCR.
//  - Sits between operand fetch and writeback, with valid/ready on both sides.
// PARAMETERS
//  WIDTH      32  operand/result width, >=2
//  STICKY_EN  1   1: sv accumulates v; 0: sv tied 0
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      operand beat valid
//  in_ready    out  1      unit can accept beat
//  op          in   3      setcc_pkg::op_t (ADD,SUB,CMP,ADDC,SUBB)
//  op1, op2    in   WIDTH  operands
//  out_valid   out  1      result beat valid
//  out_ready   in   1      consumer accepts result
//  result      out  WIDTH  registered result (CMP: op1-op2)
//  out_wr      out  1      writeback enable (0 for CMP)
//  out_flags   out  4      {c,z,n,v} produced by this op
//  ccr         out  4      architectural {c,z,n,v}
//  sv          out  1      sticky overflow
//  clr_sticky  in   1      synchronous clear of sv
//  cond_sel    in   4      setcc_pkg::cond_t
//  cond_true   out  1      combinational eval of cond_sel on ccr
// BEHAVIOUR
//  - Reset (async assert, sync-safe release):
//    out_valid=0, result=0, out_wr=0, out_flags=0, ccr=0, sv=0.
//    A beat in flight is discarded.
//  - Handshake: single-entry pipeline register.
//    - in_ready = !out_valid || out_ready (combinational, no bubble).
//    - Accept when in_valid && in_ready; the result appears next cycle with out_valid=1.
//    - out_valid, result and flags stay stable until out_ready.
//  - Latency 1 cycle; full throughput when out_ready=1.
//  - Arithmetic: WIDTH+1-bit sum.
//    - ADD:  s = op1 + op2.
//    - ADDC: s = op1 + op2 + ccr.c.
//    - SUB/CMP: s = op1 + ~op2 + 1.
//    - SUBB: s = op1 + ~op2 + !ccr.c.
//  - Flags:
//    - z = (s[WIDTH-1:0]==0); n = s[WIDTH-1].
//    - v = signed overflow (operand signs equal after op2 inversion, result sign differs).
//    - c = carry-out for ADD/ADDC; c = borrow = !carry-out for SUB/CMP/SUBB.
//  - CCR updates at the accept edge, not at the output handshake.
//    - Back-to-back ADDC/SUBB therefore see the carry of the immediately preceding accepted op.
//  - sv <= (sv & !clr_sticky) | (accept & v).
//    - Set wins over a simultaneous clear.
//  - cond_sel encoding:
//    - 0 AL, 1 NV, 2 EQ z, 3 NE !z, 4 CS c, 5 CC !c, 6 MI n, 7 PL !n.
//    - 8 VS v, 9 VC !v, A GT !z&(n==v), B GE n==v, C LT n!=v.
//    - D LE z|(n!=v), E GTU !c&!z, F LEU c|z.
//    - cond_true reflects ccr after the last accept edge (registered CCR, not the in-flight op).
//  - Unknown op codes: treated as CMP (flags update, out_wr=0).
//  - Wrap-around: results are modulo 2^WIDTH; the carry is reported only through c.
// STRUCTURE
//  - setcc_pkg: op_t and cond_t enums, FLAG_C/Z/N/V bit-index constants, flags_t struct.
//  - Sub-module setcc_flags (combinational):
//    - inputs: op, op1, op2, cin; outputs: sum[WIDTH-1:0], flags_t.
//    - Shared with the existing setcc checker model.
//  - Top holds the pipeline register, CCR/sv registers and the cond mux.
// TESTING (WIDTH=32)
//  1. ADD FFFFFFFF+00000001 -> result 0, out_flags c=1 z=1 n=0 v=0; ccr same next cycle.
//  2. SUB 80000000-00000001 -> 7FFFFFFF, v=1 n=0 c=0, sv=1; then CMP 5,5 -> z=1, out_wr=0, result 0.
//  3. ADD FFFFFFFF+1, then ADDC 0+0 back-to-back -> second result 00000001, c=0.
//  4. in_valid=1 for 4 beats, out_ready low 3 cycles after first accept:
//     - in_ready=0 while stalled;
//     - the 4 results emerge in order, none dropped or duplicated.
//  5. clr_sticky=1 in the same cycle as an overflowing ADD 7FFFFFFF+1 -> sv=1;
//     clr_sticky alone next cycle -> sv=0.
//  6. rst_n low mid-stall with out_valid=1 -> out_valid=0, ccr=0, sv=0 immediately;
//     cond_sel=2 (EQ) -> cond_true=0.

Source files
------------

// File: rtl/setcc_pkg.sv
// setcc_pkg: shared op/condition encodings, flag bit positions and flag struct
package setcc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_CMP  = 3'd2,
        OP_ADDC = 3'd3,
        OP_SUBB = 3'd4
    } op_t;

    typedef enum logic [3:0] {
        C_AL, C_NV, C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL,
        C_VS, C_VC, C_GT, C_GE, C_LT, C_LE, C_GTU, C_LEU
    } cond_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

endpackage

// File: rtl/setcc_pipe_if.sv
// setcc_pipe_if: operand/result handshake, condition query and CCR status bundle
interface setcc_pipe_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             out_wr;
    logic [3:0]       out_flags;
    logic [3:0]       ccr;
    logic             sv;
    logic             clr_sticky;
    logic [3:0]       cond_sel;
    logic             cond_true;

    modport master (
        output in_valid, op, op1, op2, out_ready, clr_sticky, cond_sel,
        input  in_ready, out_valid, result, out_wr, out_flags, ccr, sv, cond_true
    );

    modport slave (
        input  in_valid, op, op1, op2, out_ready, clr_sticky, cond_sel,
        output in_ready, out_valid, result, out_wr, out_flags, ccr, sv, cond_true
    );
endinterface

// File: rtl/setcc_flags.sv
// setcc_flags: combinational WIDTH+1-bit adder producing the sum and {c,z,n,v}
module setcc_flags
    import setcc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output flags_t           o_flags
);
    logic             w_add;
    logic [WIDTH-1:0] w_b;
    logic             w_ci;
    logic [WIDTH:0]   w_s;

    // Subtracts (and unknown codes, which behave as CMP) invert op2; c is reported as borrow for them
    always_comb begin
        w_add     = (i_op == OP_ADD) || (i_op == OP_ADDC);
        w_b       = w_add ? i_op2 : ~i_op2;
        w_ci      = (i_op == OP_ADD) ? 1'b0 : (i_op == OP_ADDC) ? i_cin : (i_op == OP_SUBB) ? !i_cin : 1'b1;
        w_s       = {1'b0, i_op1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_ci};
        o_sum     = w_s[WIDTH-1:0];
        o_flags.c = w_add ? w_s[WIDTH] : !w_s[WIDTH];
        o_flags.z = (w_s[WIDTH-1:0] == '0);
        o_flags.n = w_s[WIDTH-1];
        o_flags.v = (i_op1[WIDTH-1] == w_b[WIDTH-1]) && (w_s[WIDTH-1] != i_op1[WIDTH-1]);
    end
endmodule

// File: rtl/setcc_pipe.sv
// setcc_pipe: single-entry pipelined condition-code unit with CCR, sticky overflow and branch eval
module setcc_pipe
    import setcc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit STICKY_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    setcc_pipe_if.slave bus
);
    logic             w_accept;
    logic             w_wr;
    logic [WIDTH-1:0] w_sum;
    flags_t           w_flags;
    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_wr;
    flags_t           r_flags;
    flags_t           r_ccr;
    logic             r_sv;
    logic             w_cond;

    setcc_flags #(.WIDTH(WIDTH)) u_flags (
        .i_op    (bus.op),
        .i_op1   (bus.op1),
        .i_op2   (bus.op2),
        .i_cin   (r_ccr.c),
        .o_sum   (w_sum),
        .o_flags (w_flags)
    );

    assign bus.in_ready = !r_valid || bus.out_ready;

    // Accept decode; only real arithmetic ops write back, CMP and unknown codes do not
    always_comb begin
        w_accept = bus.in_valid && bus.in_ready;
        w_wr     = (bus.op == OP_ADD) || (bus.op == OP_SUB) || (bus.op == OP_ADDC) || (bus.op == OP_SUBB);
    end

    // Output register: load on accept, hold while stalled, drop valid once consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_wr     <= 1'b0;
            r_flags  <= '0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_result <= w_sum;
            r_wr     <= w_wr;
            r_flags  <= w_flags;
        end else if (bus.out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    // CCR tracks the accept edge so a following ADDC/SUBB sees this op's carry; sv set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ccr <= '0;
            r_sv  <= 1'b0;
        end else begin
            if (w_accept) r_ccr <= w_flags;
            r_sv <= STICKY_EN & ((r_sv & !bus.clr_sticky) | (w_accept & w_flags.v));
        end
    end

    // Branch condition evaluated on the architectural CCR
    always_comb begin
        case (cond_t'(bus.cond_sel))
            C_AL:    w_cond = 1'b1;
            C_NV:    w_cond = 1'b0;
            C_EQ:    w_cond = r_ccr.z;
            C_NE:    w_cond = !r_ccr.z;
            C_CS:    w_cond = r_ccr.c;
            C_CC:    w_cond = !r_ccr.c;
            C_MI:    w_cond = r_ccr.n;
            C_PL:    w_cond = !r_ccr.n;
            C_VS:    w_cond = r_ccr.v;
            C_VC:    w_cond = !r_ccr.v;
            C_GT:    w_cond = !r_ccr.z && (r_ccr.n == r_ccr.v);
            C_GE:    w_cond = (r_ccr.n == r_ccr.v);
            C_LT:    w_cond = (r_ccr.n != r_ccr.v);
            C_LE:    w_cond = r_ccr.z || (r_ccr.n != r_ccr.v);
            C_GTU:   w_cond = !r_ccr.c && !r_ccr.z;
            default: w_cond = r_ccr.c || r_ccr.z;
        endcase
    end

    assign bus.out_valid = r_valid;
    assign bus.result    = r_result;
    assign bus.out_wr    = r_wr;
    assign bus.out_flags = r_flags;
    assign bus.ccr       = r_ccr;
    assign bus.sv        = r_sv;
    assign bus.cond_true = w_cond;
endmodule
